// File: rtl/wb_pkg.sv
// Wishbone types and widths shared by the on-chip RAM responder and the
// cache-side initiator.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;
  localparam int WB_AMAX = 32;

  // Addresses are carried at full width so differently sized responders can share the type
  typedef struct packed {
    logic               we;
    logic [WB_AMAX-1:0] adr;
    logic [WB_DW-1:0]   dat;
    logic [WB_SELW-1:0] sel;
  } wb_req_t;

  typedef struct packed {
    logic             ack;
    logic             err;
    logic [WB_DW-1:0] dat;
  } wb_rsp_t;

endpackage

// File: rtl/wb_pipelined_ram_resp_if.sv
// Pipelined Wishbone B4 bus bundle; the initiator drives through master and
// the RAM responder answers through slave.
interface wb_pipelined_ram_resp_if
  import wb_pkg::*;
#(
  parameter int AW = 12
);

  logic               cyc;
  logic               stb;
  logic               we;
  logic [AW-1:0]      adr;
  logic [WB_DW-1:0]   dat_w;
  logic [WB_SELW-1:0] sel;
  logic               stall;
  logic               ack;
  logic               err;
  logic [WB_DW-1:0]   dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  stall, ack, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output stall, ack, err, dat_r
  );

endinterface

// File: rtl/wb_resp_pipe.sv
// Fixed-latency response shift register: each accepted request enters at
// stage 0 and leaves as a one-cycle ack or err pulse LAT cycles later.
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WB_DW-1:0] in_dat,
  output wb_rsp_t          rsp
);

  logic [LAT-1:0]   valid;
  logic [LAT-1:0]   err;
  logic [WB_DW-1:0] dat [LAT];

  // Only the valid bits are flushed; payload is ignored once its valid bit is gone
  always_ff @(posedge clk) begin
    if (flush) begin
      valid <= '0;
    end else begin
      valid[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        valid[i] <= valid[i-1];
      end
    end
    err[0] <= in_err;
    dat[0] <= in_dat;
    for (int i = 1; i < LAT; i++) begin
      err[i] <= err[i-1];
      dat[i] <= dat[i-1];
    end
  end

  always_comb begin
    rsp     = '0;
    rsp.ack = valid[LAT-1] & ~err[LAT-1];
    rsp.err = valid[LAT-1] & err[LAT-1];
    rsp.dat = rsp.ack ? dat[LAT-1] : '0;
  end

endmodule

// File: rtl/wb_pipelined_ram_resp.sv
// Word-addressed on-chip RAM behind a pipelined Wishbone slave port, with a
// bounded number of outstanding requests and optional periodic stall injection.
module wb_pipelined_ram_resp
  import wb_pkg::*;
#(
  parameter int AW           = 12,
  parameter int DEPTH        = 2**AW,
  parameter int LAT          = 2,
  parameter int MAX_OUT      = 4,
  parameter int STALL_PERIOD = 0
) (
  input logic                     cpu_clock_i,
  input logic                     cpu_reset_i,
  wb_pipelined_ram_resp_if.slave  bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  logic [WB_DW-1:0] mem [DEPTH];

  wb_req_t          req;
  wb_rsp_t          rsp;
  logic             in_range;
  logic [IW-1:0]    ram_idx;
  logic [WB_DW-1:0] rd_dat;
  logic             accept;
  logic             stall;
  logic             inject;
  logic             rsp_fire;
  logic             flush;
  logic [OW-1:0]    outstanding;
  logic [CW-1:0]    stall_cnt;

  always_comb begin
    req     = '0;
    req.we  = bus.we;
    req.adr = WB_AMAX'(bus.adr);
    req.dat = bus.dat_w;
    req.sel = bus.sel;
  end

  assign in_range = (req.adr < WB_AMAX'(DEPTH));
  assign ram_idx  = req.adr[IW-1:0];

  // Stall depends only on registered state and reset, never on the strobe
  assign inject   = (STALL_PERIOD != 0) && (stall_cnt == CW'(STALL_PERIOD - 1));
  assign stall    = cpu_reset_i | (outstanding == OW'(MAX_OUT)) | inject;
  assign accept   = bus.cyc & bus.stb & ~stall;
  assign rsp_fire = rsp.ack | rsp.err;
  assign flush    = cpu_reset_i | ~bus.cyc;

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i || stall_cnt == CW'(STALL_PERIOD - 1)) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (flush) begin
      outstanding <= '0;
    end else if (accept && !rsp_fire) begin
      outstanding <= outstanding + OW'(1);
    end else if (!accept && rsp_fire) begin
      outstanding <= outstanding - OW'(1);
    end
  end

  // Byte-lane writes; the array is deliberately left out of reset
  always_ff @(posedge cpu_clock_i) begin
    if (accept && req.we && in_range) begin
      for (int b = 0; b < WB_SELW; b++) begin
        if (req.sel[b]) begin
          mem[ram_idx][8*b +: 8] <= req.dat[8*b +: 8];
        end
      end
    end
  end

  // Read happens at acceptance, so a write one cycle earlier is already visible
  assign rd_dat = (in_range && !req.we) ? mem[ram_idx] : '0;

  wb_resp_pipe #(
    .LAT (LAT)
  ) u_pipe (
    .clk      (cpu_clock_i),
    .flush    (flush),
    .in_valid (accept),
    .in_err   (~in_range),
    .in_dat   (rd_dat),
    .rsp      (rsp)
  );

  assign bus.stall = stall;
  assign bus.ack   = rsp.ack;
  assign bus.err   = rsp.err;
  assign bus.dat_r = rsp.dat;

endmodule

// File: tb/tb_wb_pipelined_ram_resp.sv
// Randomised bench for the pipelined RAM responder, checked every cycle against
// a queue-based transaction model of the bus rules.
module tb_wb_pipelined_ram_resp;

  localparam int AW           = 12;
  localparam int DEPTH        = 1024;
  localparam int LAT          = 3;
  localparam int MAX_OUT      = 2;
  localparam int STALL_PERIOD = 5;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] dat;
  } exp_rsp_t;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  wb_pipelined_ram_resp_if #(.AW(AW)) bus ();

  wb_pipelined_ram_resp #(
    .AW           (AW),
    .DEPTH        (DEPTH),
    .LAT          (LAT),
    .MAX_OUT      (MAX_OUT),
    .STALL_PERIOD (STALL_PERIOD)
  ) dut (
    .cpu_clock_i (clock),
    .cpu_reset_i (reset),
    .bus         (bus)
  );

  exp_rsp_t    pending[$];
  logic [31:0] refMem [DEPTH];
  int          cycleNo;
  int          stallPhase;
  int          testsRun;
  int          testsFailed;
  logic        lastAccept;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  // One bus cycle: compare outputs mid-cycle, then advance the model at the edge
  task automatic stepCycle();
    logic        due;
    logic        expStall;
    logic [31:0] expDat;
    exp_rsp_t    r;
    @(negedge clock);
    due      = (pending.size() > 0) && (pending[0].due == cycleNo);
    expStall = reset || (pending.size() == MAX_OUT) || (stallPhase == STALL_PERIOD - 1);
    expDat   = (due && !pending[0].err) ? pending[0].dat : 32'h0;
    checkOutput("stall", 32'(bus.stall), 32'(expStall));
    checkOutput("ack", 32'(bus.ack), 32'(due && !pending[0].err));
    checkOutput("err", 32'(bus.err), 32'(due && pending[0].err));
    checkOutput("dat", bus.dat_r, expDat);
    lastAccept = !reset && bus.cyc && bus.stb && !expStall;
    @(posedge clock);
    if (reset) begin
      pending.delete();
      stallPhase = 0;
    end else begin
      stallPhase = (stallPhase + 1) % STALL_PERIOD;
      if (due) void'(pending.pop_front());
      if (!bus.cyc) pending.delete();
      if (lastAccept) begin
        r.due = cycleNo + LAT;
        r.err = (int'(bus.adr) >= DEPTH);
        r.dat = 32'h0;
        if (!r.err) begin
          if (bus.we) begin
            for (int b = 0; b < 4; b++) begin
              if (bus.sel[b]) refMem[int'(bus.adr)][8*b +: 8] = bus.dat_w[8*b +: 8];
            end
          end else begin
            r.dat = refMem[int'(bus.adr)];
          end
        end
        pending.push_back(r);
      end
    end
    cycleNo++;
    #1;
  endtask

  // Present one request and hold it until the bus accepts it
  task automatic applyStimulus(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = we;
    bus.adr   = adr;
    bus.dat_w = dat;
    bus.sel   = sel;
    lastAccept = 1'b0;
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      if (lastAccept) break;
    end
    if (!lastAccept) checkOutput("accept_timeout", 32'(lastAccept), 32'h1);
    bus.stb = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.stb = 1'b0;
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    int accepts;
    testsRun    = 0;
    testsFailed = 0;
    cycleNo     = 0;
    stallPhase  = 0;
    reset       = 1'b1;
    bus.cyc     = 1'b0;
    bus.stb     = 1'b0;
    bus.we      = 1'b0;
    bus.adr     = '0;
    bus.dat_w   = '0;
    bus.sel     = '0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) stepCycle();
    reset   = 1'b0;
    bus.cyc = 1'b1;

    // Give the low words and the alias target of 0x7FF known contents
    for (int a = 0; a < 32; a++) applyStimulus(1'b1, AW'(a), $urandom, 4'hF);
    applyStimulus(1'b1, 12'h3FF, $urandom, 4'hF);
    applyStimulus(1'b1, 12'h000, 32'h0BADF00D, 4'hF);
    idle(LAT + 2);

    applyStimulus(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b0, 12'h010, 32'h0, 4'h0);
    idle(LAT + 2);

    applyStimulus(1'b1, 12'h005, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 12'h005, 32'hAABBCCDD, 4'b0101);
    applyStimulus(1'b1, 12'h006, 32'hFFFFFFFF, 4'h0);
    applyStimulus(1'b0, 12'h005, 32'h0, 4'h0);
    applyStimulus(1'b0, 12'h006, 32'h0, 4'h0);
    idle(LAT + 2);

    applyStimulus(1'b0, 12'h400, 32'h0, 4'h0);
    applyStimulus(1'b1, 12'h7FF, 32'h12345678, 4'hF);
    applyStimulus(1'b0, 12'h3FF, 32'h0, 4'h0);
    applyStimulus(1'b0, 12'h000, 32'h0, 4'h0);
    idle(LAT + 2);

    for (int a = 0; a < 6; a++) applyStimulus(1'b0, AW'(a), 32'h0, 4'h0);
    idle(LAT + 2);

    // Abort with two reads in flight, then resume normally
    applyStimulus(1'b0, 12'h001, 32'h0, 4'h0);
    applyStimulus(1'b0, 12'h002, 32'h0, 4'h0);
    bus.cyc = 1'b0;
    stepCycle();
    bus.cyc = 1'b1;
    idle(LAT + 1);
    applyStimulus(1'b0, 12'h003, 32'h0, 4'h0);
    idle(LAT + 2);

    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we  = 1'b0;
    bus.adr = 12'h007;
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      if (lastAccept) accepts++;
    end
    idle(LAT + 2);

    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      bus.cyc   = ($urandom_range(0, 15) != 0);
      bus.stb   = $urandom_range(0, 1) == 1;
      bus.we    = $urandom_range(0, 2) == 0;
      bus.adr   = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 4095)) : AW'($urandom_range(0, 31));
      bus.dat_w = $urandom;
      bus.sel   = 4'($urandom_range(0, 15));
      stepCycle();
    end
    reset   = 1'b0;
    bus.cyc = 1'b1;
    idle(LAT + 2);

    // Reset arrives while two reads are pending
    applyStimulus(1'b0, 12'h008, 32'h0, 4'h0);
    applyStimulus(1'b0, 12'h009, 32'h0, 4'h0);
    reset = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    idle(LAT + 3);
    applyStimulus(1'b0, 12'h009, 32'h0, 4'h0);
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
